reg_file_scoreboard: RTL

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/reg_file_scoreboard.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with two read ports, two write ports and a per-register busy
// scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadAddress1,
    input  logic [ADDR_WIDTH-1:0] ReadAddress2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadReady1,
    output logic                  ReadReady2,
    input  logic                  WriteEnable0,
    input  logic                  WriteEnable1,
    input  logic [ADDR_WIDTH-1:0] WriteAddress0,
    input  logic [ADDR_WIDTH-1:0] WriteAddress1,
    input  logic [DATA_WIDTH-1:0] WriteData0,
    input  logic [DATA_WIDTH-1:0] WriteData1,
    input  logic                  IssueValid,
    input  logic [ADDR_WIDTH-1:0] IssueAddress,
    output logic [ADDR_WIDTH:0]   BusyCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busy_count_q;
    logic [ADDR_WIDTH:0]   busy_count_d;

    logic [ADDR_WIDTH-1:0] rd_addr  [2];
    logic [DATA_WIDTH-1:0] rd_data  [2];
    logic                  rd_ready [2];

    logic wr0_hit;
    logic wr1_hit;
    logic iss_hit;

    // Register 0 is never busy, so the count tops out at DEPTH-1 and fits ADDR_WIDTH+1 bits.
    function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] bits);
        logic [ADDR_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, bits[i]};
        end
        return cnt;
    endfunction

    assign wr0_hit = WriteEnable0 && (WriteAddress0 != '0);
    assign wr1_hit = WriteEnable1 && (WriteAddress1 != '0);
    assign iss_hit = IssueValid && (IssueAddress != '0);

    // Port 1 is applied after port 0 so it wins on a shared address; the issue
    // is applied last so a new producer keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_hit) begin
            regs_d[WriteAddress0] = WriteData0;
            busy_d[WriteAddress0] = 1'b0;
        end
        if (wr1_hit) begin
            regs_d[WriteAddress1] = WriteData1;
            busy_d[WriteAddress1] = 1'b0;
        end
        if (iss_hit) begin
            busy_d[IssueAddress] = 1'b1;
        end
        busy_count_d = popcount(busy_d);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign rd_addr[0] = ReadAddress1;
    assign rd_addr[1] = ReadAddress2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (rd_addr[p] == '0) begin
                rd_data[p]  = '0;
                rd_ready[p] = 1'b1;
            end else begin
                rd_data[p]  = regs_q[rd_addr[p]];
                rd_ready[p] = ~busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr0_hit && (WriteAddress0 == rd_addr[p])) begin
                    rd_data[p]  = WriteData0;
                    rd_ready[p] = 1'b1;
                end
                if (wr1_hit && (WriteAddress1 == rd_addr[p])) begin
                    rd_data[p]  = WriteData1;
                    rd_ready[p] = 1'b1;
                end
`else
`endif
            end
        end
    end

    assign ReadData1  = rd_data[0];
    assign ReadData2  = rd_data[1];
    assign ReadReady1 = rd_ready[0];
    assign ReadReady2 = rd_ready[1];
    assign BusyCount  = busy_count_q;

endmodule
